// File: rtl/note_sprite_plotter.sv
// Rasterises one note-draw request into a NOTE_W x NOTE_H filled rectangle, one pixel per clk,
// clipped to the visible area. Optional NOTE_OUTLINE_EN macro paints the perimeter in white.
module note_sprite_plotter #(
  parameter int NOTE_W = 12,
  parameter int NOTE_H = 6,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] x0_r;
  logic [6:0] y0_r;
  logic [2:0] col_r;
  logic [3:0] dx_r;
  logic [3:0] dy_r;
  logic [7:0] hold_x_r;
  logic [6:0] hold_y_r;
  logic [2:0] hold_col_r;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;

  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;
  logic       draw_s;
  logic       in_view_s;
  logic [2:0] pix_col_s;

  // Pixel address, clip test and pixel colour for the current raster position
  always_comb begin
    sum_x_s   = {1'b0, x0_r} + {5'b0_0000, dx_r};
    sum_y_s   = {1'b0, y0_r} + {4'b0000, dy_r};
    draw_s    = (state_r == DRAW);
    in_view_s = (sum_x_s <= 9'(X_MAX)) && (sum_y_s <= 8'(Y_MAX));
`ifdef NOTE_OUTLINE_EN
    // Black stays black everywhere so an erase never leaves a white frame behind
    if (col_r == 3'b000) begin
      pix_col_s = 3'b000;
    end else if ((dx_r == 4'd0) || (dx_r == 4'(NOTE_W - 1)) ||
                 (dy_r == 4'd0) || (dy_r == 4'(NOTE_H - 1))) begin
      pix_col_s = 3'b111;
    end else begin
      pix_col_s = col_r;
    end
`else
    pix_col_s = col_r;
`endif
  end

  // Live pixel while drawing, otherwise the last pixel sent is held
  always_comb begin
    if (draw_s) begin
      vga_x      = sum_x_s[7:0];
      vga_y      = sum_y_s[6:0];
      vga_colour = pix_col_s;
    end else begin
      vga_x      = hold_x_r;
      vga_y      = hold_y_r;
      vga_colour = hold_col_r;
    end
    vga_plot  = draw_s && in_view_s;
    req_ready = ready_r;
    busy      = busy_r;
    done      = done_r;
  end

  // Sprite sequencer: accept, raster scan, completion pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      x0_r       <= 8'd0;
      y0_r       <= 7'd0;
      col_r      <= 3'd0;
      dx_r       <= 4'd0;
      dy_r       <= 4'd0;
      hold_x_r   <= 8'd0;
      hold_y_r   <= 7'd0;
      hold_col_r <= 3'd0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (req_valid && ready_r) begin
            x0_r    <= req_x;
            y0_r    <= req_y;
            col_r   <= req_colour;
            dx_r    <= 4'd0;
            dy_r    <= 4'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= DRAW;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        DRAW: begin
          hold_x_r   <= sum_x_s[7:0];
          hold_y_r   <= sum_y_s[6:0];
          hold_col_r <= pix_col_s;
          if (dx_r == 4'(NOTE_W - 1)) begin
            dx_r <= 4'd0;
            if (dy_r == 4'(NOTE_H - 1)) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              dy_r <= dy_r + 4'd1;
            end
          end else begin
            dx_r <= dx_r + 4'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sprite_plotter.sv
// Directed bench for note_sprite_plotter: reset, full sprite, clipping, back-to-back,
// reset mid-draw and colour handling (honours NOTE_OUTLINE_EN when defined).
module tb_note_sprite_plotter;

  localparam int NW = 12;
  localparam int NH = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int plot_cnt = 0;

  note_sprite_plotter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_col(input logic [2:0] c, input int dx, input int dy);
`ifdef NOTE_OUTLINE_EN
    if (c == 3'b000) return 3'b000;
    if (dx == 0 || dx == NW - 1 || dy == 0 || dy == NH - 1) return 3'b111;
    return c;
`else
    return c;
`endif
  endfunction

  // Called at a negedge with req_ready high; returns at a negedge with req_ready high again.
  task automatic draw_and_check(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                                input bit hold_next, input string tag);
    int ex, ey, dx, dy;
    logic [2:0] last_col;
    check({tag, "_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_x = x; req_y = y; req_colour = c;
    @(posedge clk);
    for (int i = 0; i < NW * NH; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold_next) begin
          req_x = 8'd64; req_y = 7'd10; req_colour = 3'b101;
        end else begin
          req_valid = 1'b0;
        end
        check({tag, "_ready_draw"}, req_ready, 1'b0);
        check({tag, "_busy_draw"}, busy, 1'b1);
      end
      dx = i % NW; dy = i / NW;
      ex = int'(x) + dx; ey = int'(y) + dy;
      last_col = exp_col(c, dx, dy);
      check({tag, "_plot"}, vga_plot, (ex <= 159 && ey <= 119) ? 1'b1 : 1'b0);
      check({tag, "_x"}, vga_x, ex & 8'hff);
      check({tag, "_y"}, vga_y, ey & 7'h7f);
      check({tag, "_col"}, vga_colour, last_col);
      check({tag, "_done_draw"}, done, 1'b0);
      if (vga_plot === 1'b1) plot_cnt++;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_plot_done"}, vga_plot, 1'b0);
    check({tag, "_ready_done"}, req_ready, 1'b0);
    check({tag, "_busy_done"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_done_clear"}, done, 1'b0);
    check({tag, "_ready_after"}, req_ready, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_plot_after"}, vga_plot, 1'b0);
    check({tag, "_hold_x"}, vga_x, (int'(x) + NW - 1) & 8'hff);
    check({tag, "_hold_y"}, vga_y, (int'(y) + NH - 1) & 7'h7f);
    check({tag, "_hold_col"}, vga_colour, last_col);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_x = 8'd0; req_y = 7'd0; req_colour = 3'd0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_x", vga_x, 8'd0);
    check("rst_col", vga_colour, 3'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rel_ready", req_ready, 1'b1);
    check("rel_plot", vga_plot, 1'b0);

    // Basic sprite
    draw_and_check(8'd48, 7'd1, 3'b010, 1'b0, "basic");

    // Clipping at the bottom-right corner
    plot_cnt = 0;
    draw_and_check(8'd150, 7'd115, 3'b110, 1'b0, "clip");
    check("clip_count", plot_cnt, 50);

    // Back-to-back with req_valid held and inputs changed mid-draw
    draw_and_check(8'd48, 7'd1, 3'b011, 1'b1, "b2b1");
    draw_and_check(8'd64, 7'd10, 3'b101, 1'b0, "b2b2");

    // Colour handling (outline when enabled) and erase
    draw_and_check(8'd48, 7'd1, 3'b001, 1'b0, "col001");
    draw_and_check(8'd48, 7'd1, 3'b000, 1'b0, "erase");

    // Reset in the 20th DRAW cycle
    req_valid = 1'b1; req_x = 8'd20; req_y = 7'd30; req_colour = 3'b011;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_plot19", vga_plot, 1'b1);
    check("mid_x19", vga_x, 8'd26);
    check("mid_y19", vga_y, 7'd31);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_plot", vga_plot, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_x", vga_x, 8'd0);
    @(negedge clk);
    check("mid_rst_done2", done, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", req_ready, 1'b1);
    check("mid_rel_done", done, 1'b0);
    check("mid_rel_plot", vga_plot, 1'b0);
    draw_and_check(8'd0, 7'd0, 3'b100, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
